// File: rtl/alu_pkg.sv
// Shared opcode and FSM state types for the sequential ALU.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_MUL = 3'b100,
        OP_XOR = 3'b101,
        OP_SHL = 3'b110,
        OP_SHR = 3'b111
    } alu_op_e;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } alu_state_e;

endpackage

// File: rtl/shift_add_mul.sv
// Iterative shift-add multiplier: one partial product per i_step cycle, N steps total.
module shift_add_mul #(
    parameter int N = 4
) (
    input  logic           i_clk,
    input  logic           i_reset,
    input  logic           i_start,
    input  logic           i_step,
    input  logic [N-1:0]   i_a,
    input  logic [N-1:0]   i_b,
    output logic           o_done,
    output logic [2*N-1:0] o_product
);
    localparam int CW = $clog2(N);

    logic [2*N-1:0] r_mcand;
    logic [N-1:0]   r_mplier;
    logic [2*N-1:0] r_prod;
    logic [CW-1:0]  r_cnt;
    logic [2*N-1:0] w_prod_nxt;

    // The final step's sum is exposed combinationally so the top can register it on done.
    assign w_prod_nxt = r_prod + (r_mplier[0] ? r_mcand : '0);
    assign o_product  = w_prod_nxt;
    assign o_done     = i_step && (r_cnt == CW'(N-1));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
            r_cnt    <= '0;
        end else if (i_start) begin
            r_mcand  <= {{N{1'b0}}, i_a};
            r_mplier <= i_b;
            r_prod   <= '0;
            r_cnt    <= '0;
        end else if (i_step) begin
            r_prod   <= w_prod_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Registered multi-cycle ALU: single-cycle logic/arith ops, N-cycle multiply, valid/ready input.
module seq_alu
    import alu_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic [2:0]   i_op,
    output logic         o_valid,
    output logic [N-1:0] o_result,
    output logic         o_carry,
    output logic         o_zero
);
    alu_state_e     r_state, w_next;
    logic [N-1:0]   r_result;
    logic           r_carry, r_zero, r_valid;
    logic [N:0]     w_ext;
    logic           w_accept, w_is_mul, w_mul_done;
    logic [2*N-1:0] w_prod;

    assign o_ready    = (r_state == ST_IDLE);
    assign w_accept   = i_valid && o_ready;
    assign w_is_mul   = (alu_op_e'(i_op) == OP_MUL);

    shift_add_mul #(.N(N)) u_mul (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_start   (w_accept && w_is_mul),
        .i_step    (r_state == ST_MUL),
        .i_a       (i_a),
        .i_b       (i_b),
        .o_done    (w_mul_done),
        .o_product (w_prod)
    );

    // Bit N of the extended result is the carry for every single-cycle op.
    always_comb begin
        w_ext = '0;
        case (alu_op_e'(i_op))
            OP_ADD:  w_ext = {1'b0, i_a} + {1'b0, i_b};
            OP_SUB:  w_ext = {1'b0, i_a} + {1'b0, ~i_b} + (N+1)'(1);
            OP_AND:  w_ext = {1'b0, i_a & i_b};
            OP_OR:   w_ext = {1'b0, i_a | i_b};
            OP_XOR:  w_ext = {1'b0, i_a ^ i_b};
            OP_SHL:  w_ext = {i_a, 1'b0};
            OP_SHR:  w_ext = {i_a[0], 1'b0, i_a[N-1:1]};
            default: w_ext = '0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= ST_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept && w_is_mul) w_next = ST_MUL;
            ST_MUL:  if (w_mul_done)           w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_result <= '0;
            r_carry  <= 1'b0;
            r_zero   <= 1'b1;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (w_accept && !w_is_mul) begin
                r_result <= w_ext[N-1:0];
                r_carry  <= w_ext[N];
                r_zero   <= (w_ext[N-1:0] == '0);
                r_valid  <= 1'b1;
            end else if (w_mul_done) begin
                r_result <= w_prod[N-1:0];
                r_carry  <= |w_prod[2*N-1:N];
                r_zero   <= (w_prod[N-1:0] == '0);
                r_valid  <= 1'b1;
            end
        end
    end

    assign o_valid  = r_valid;
    assign o_result = r_result;
    assign o_carry  = r_carry;
    assign o_zero   = r_zero;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (N=4): vector table, handshake corner cases, random ops vs model.
module tb_seq_alu;
    localparam int N = 4;
    localparam int M = 1 << N;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_valid;
    logic         o_ready;
    logic [N-1:0] i_a, i_b;
    logic [2:0]   i_op;
    logic         o_valid;
    logic [N-1:0] o_result;
    logic         o_carry, o_zero;

    int checks = 0;
    int errors = 0;

    seq_alu #(.N(N)) dut (
        .i_clk    (clk),
        .i_reset  (rst),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_a      (i_a),
        .i_b      (i_b),
        .i_op     (i_op),
        .o_valid  (o_valid),
        .o_result (o_result),
        .o_carry  (o_carry),
        .o_zero   (o_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   op;
        logic [N-1:0] a, b;
        logic [N-1:0] res;
        logic         cy, zr;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the opcode rules.
    task automatic model(input int op, input int a, input int b,
                         output int res, output int cy);
        int p;
        case (op)
            0: begin p = a + b;          res = p % M; cy = (p >= M); end
            1: begin res = (a - b + M) % M; cy = (a >= b); end
            2: begin res = a & b;        cy = 0; end
            3: begin res = a | b;        cy = 0; end
            4: begin p = a * b;          res = p % M; cy = (p >= M); end
            5: begin res = a ^ b;        cy = 0; end
            6: begin res = (a * 2) % M;  cy = (a >= M / 2); end
            default: begin res = a / 2;  cy = a % 2; end
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op from idle, wait for completion, check latency, ready-low span, outputs, pulse width.
    task automatic do_op(input string name, input int op, input int a, input int b,
                         input int eres, input int ecy);
        int edges, rdy_low;
        i_op = 3'(op); i_a = N'(a); i_b = N'(b); i_valid = 1'b1;
        chk({name, " ready_before"}, int'(o_ready), 1);
        tick();
        i_valid = 1'b0;
        edges = 0;
        rdy_low = o_ready ? 0 : 1;
        while (!o_valid && edges < 20) begin
            tick();
            edges++;
            if (!o_ready) rdy_low++;
        end
        chk({name, " latency"}, edges, (op == 4) ? N : 0);
        chk({name, " ready_low_cycles"}, rdy_low, (op == 4) ? N : 0);
        chk({name, " result"}, int'(o_result), eres);
        chk({name, " carry"}, int'(o_carry), ecy);
        chk({name, " zero"}, int'(o_zero), (eres == 0) ? 1 : 0);
        tick();
        chk({name, " pulse"}, int'(o_valid), 0);
        chk({name, " held"}, int'(o_result), eres);
    endtask

    vec_t vt[$];

    initial begin
        int r, c;
        rst = 1'b1; i_valid = 1'b0; i_a = '0; i_b = '0; i_op = '0;
        #2;
        chk("rst result", int'(o_result), 0);
        chk("rst zero",   int'(o_zero),   1);
        chk("rst carry",  int'(o_carry),  0);
        chk("rst ready",  int'(o_ready),  1);
        chk("rst valid",  int'(o_valid),  0);
        tick();
        rst = 1'b0;

        vt.push_back('{3'd0, 4'd7, 4'd9, 4'h0, 1'b1, 1'b1});
        vt.push_back('{3'd1, 4'd3, 4'd5, 4'hE, 1'b0, 1'b0});
        vt.push_back('{3'd1, 4'd5, 4'd5, 4'h0, 1'b1, 1'b1});
        vt.push_back('{3'd6, 4'h9, 4'h0, 4'h2, 1'b1, 1'b0});
        vt.push_back('{3'd7, 4'h9, 4'h0, 4'h4, 1'b1, 1'b0});
        vt.push_back('{3'd4, 4'd7, 4'd6, 4'hA, 1'b1, 1'b0});
        vt.push_back('{3'd4, 4'd3, 4'd5, 4'hF, 1'b0, 1'b0});
        vt.push_back('{3'd4, 4'hF, 4'hF, 4'h1, 1'b1, 1'b0});
        vt.push_back('{3'd4, 4'h0, 4'h9, 4'h0, 1'b0, 1'b1});
        foreach (vt[i])
            do_op($sformatf("vec%0d", i), int'(vt[i].op), int'(vt[i].a), int'(vt[i].b),
                  int'(vt[i].res), int'(vt[i].cy));
        foreach (vt[i])
            chk($sformatf("vec%0d zero_tbl", i), int'(vt[i].zr), (vt[i].res == 0) ? 1 : 0);

        // Back-to-back AND/OR/XOR, one result per cycle.
        i_a = 4'hC; i_b = 4'hA; i_valid = 1'b1;
        i_op = 3'd2; tick(); chk("b2b and", int'(o_result), 8);  chk("b2b and v", int'(o_valid), 1);
        i_op = 3'd3; tick(); chk("b2b or",  int'(o_result), 14); chk("b2b or v",  int'(o_valid), 1);
        i_op = 3'd5; tick(); chk("b2b xor", int'(o_result), 6);  chk("b2b xor v", int'(o_valid), 1);
        i_valid = 1'b0;
        tick();
        chk("b2b end", int'(o_valid), 0);

        // ADD held on i_valid during a MUL must wait for ready.
        i_op = 3'd4; i_a = 4'd7; i_b = 4'd6; i_valid = 1'b1;
        tick();
        i_op = 3'd0; i_a = 4'd1; i_b = 4'd1;
        for (int k = 0; k < N - 1; k++) begin
            tick();
            chk($sformatf("hold busy%0d", k), int'(o_valid), 0);
        end
        tick();
        chk("hold mul v",   int'(o_valid),  1);
        chk("hold mul res", int'(o_result), 10);
        tick();
        i_valid = 1'b0;
        chk("hold add v",   int'(o_valid),  1);
        chk("hold add res", int'(o_result), 2);
        tick();

        // Reset on cycle 2 of a multiply aborts it.
        i_op = 3'd4; i_a = 4'd7; i_b = 4'd6; i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("abort result", int'(o_result), 0);
        chk("abort zero",   int'(o_zero),   1);
        chk("abort ready",  int'(o_ready),  1);
        chk("abort valid",  int'(o_valid),  0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < N + 1; k++) begin
            tick();
            chk($sformatf("abort quiet%0d", k), int'(o_valid), 0);
        end
        do_op("post-reset add", 0, 2, 3, 5, 0);

        // Random ops against the model.
        for (int k = 0; k < 60; k++) begin
            int op, a, b;
            op = int'($urandom_range(0, 7));
            a  = int'($urandom_range(0, M - 1));
            b  = int'($urandom_range(0, M - 1));
            model(op, a, b, r, c);
            do_op($sformatf("rnd%0d op%0d a%0d b%0d", k, op, a, b), op, a, b, r, c);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, registered, multi-cycle ALU with a valid/ready input handshake, an 8-operation set including an iterative shift-add multiplier, and registered carry/zero flags. It replaces the purely combinational 4-bit, 2-bit-control ALU in the board-level datapath. The DE10-Lite top drives it from switches and a debounced key strobe, and shows the held result on the seven-segment decoders.

## Interface
- `N`, default 4: operand and result width, N ≥ 2.
- `i_clk`  in  1: single clock; all state changes on the rising edge.
- `i_reset`  in  1: reset, asynchronous and active-high.
- `i_valid`  in  1: operands and opcode are valid this cycle.
- `o_ready`  out  1: block can accept an operation this cycle.
- `i_a`  in  N: operand A.
- `i_b`  in  N: operand B.
- `i_op`  in  3: opcode, see Operation.
- `o_valid`  out  1: one-cycle pulse; result and flags updated this cycle.
- `o_result`  out  N: result, held until the next completion.
- `o_carry`  out  1: carry flag, held with the result.
- `o_zero`  out  1: asserted when o_result == 0, held with the result.

## Operation
- An operation is accepted on a rising edge where `i_valid && o_ready`. `i_a`, `i_b` and `i_op` are latched on that edge. The inputs may change freely afterwards.
- Opcodes, where carry is bit N of the extended (N+1)-bit computation:
  - 000 ADD: a+b, carry = unsigned carry-out.
  - 001 SUB: a+~b+1, carry = 1 when a ≥ b (no borrow).
  - 010 AND: carry 0.
  - 011 OR: carry 0.
  - 100 MUL: low N bits of the 2N-bit product, carry = OR of the high N bits (unsigned overflow).
  - 101 XOR: carry 0.
  - 110 SHL: a<<1, carry = a[N-1]; b is ignored.
  - 111 SHR: logical a>>1, carry = a[0]; b is ignored.
- All arithmetic is unsigned and modulo 2^N. There is no signed overflow flag.
- FSM states:
  - IDLE: o_ready=1.
    - Accept of a non-MUL op: compute, register the outputs, pulse o_valid, stay in IDLE.
    - Accept of MUL: load the multiplicand, multiplier, 2N-bit product = 0 and a step counter = 0, then go to MUL.
  - MUL: o_ready=0. Each cycle, if multiplier[0] then add the multiplicand (shifted) into the product. Shift, then increment the counter.
    - After step N-1, register the result and flags, pulse o_valid and return to IDLE.
- `i_valid` while `o_ready`=0 is ignored; nothing is queued. The source must hold or re-present the operation.
- Output flags and result change only on completion. Between completions they hold their last values.
- There is no output back-pressure. The consumer must take `o_valid` as a single-cycle strobe.

## Timing
- Reset values: o_result=0, o_carry=0, o_zero=1, o_valid=0, o_ready=1, FSM=IDLE, counter=0.
- Non-MUL latency is 1. If accepted at edge t, o_valid=1 in the cycle after edge t with the new result. A new accept is possible at edge t+1, giving back-to-back throughput of 1 op per cycle.
- MUL latency is N. If accepted at edge t, o_ready=0 after edges t..t+N-1. After edge t+N, o_valid=1, o_ready=1 and the result is updated. The next accept is possible at edge t+N+1 at the earliest.
- Reset asserted mid-MUL aborts the multiply immediately, with no o_valid and all outputs at reset values. After release, the first accept is possible on the first edge.
- Reset asserted in the same cycle as `i_valid` loses the operation.

## Structure
- Shared package `alu_pkg`:
  - `alu_op_e` enum (3-bit) for the eight opcodes.
  - `alu_state_e` for {IDLE, MUL}.
- Sub-module `shift_add_mul #(N)` holds the multiplier datapath: multiplicand/multiplier/product registers, step counter, start/done. `seq_alu` holds the handshake, the FSM, the combinational single-cycle ops and the output registers.

## Test plan
All scenarios use N=4.
- After reset, without any clock edge: o_result=0, o_zero=1, o_carry=0, o_ready=1, o_valid=0.
- ADD 7+9 gives o_valid pulse after 1 cycle with result 0, carry=1, zero=1. SUB 3-5 gives result 0xE, carry=0, zero=0. SUB 5-5 gives result 0, carry=1, zero=1.
- Back-to-back AND 0xC,0xA then OR 0xC,0xA then XOR 0xC,0xA: three consecutive o_valid cycles with results 0x8, 0xE, 0x6. SHL 0x9 gives result 0x2, carry=1. SHR 0x9 gives result 0x4, carry=1.
- MUL 7×6: o_ready=0 for exactly 4 cycles, then o_valid with result 0xA, carry=1 (42=0x2A). MUL 3×5 gives result 0xF, carry=0.
- `i_valid` held high with ADD 1+1 during a MUL has no effect until o_ready returns. It is then accepted and gives result 2 one cycle later.
- Reset pulsed on cycle 2 of MUL 7×6: no o_valid, outputs return to reset values. A subsequent ADD 2+3 gives result 5 with latency 1.
